// File: rtl/mc_burst_addr_gen_pkg.sv
// Shared definitions for the burst address sequencer: state encodings and
// default address/length widths.
package mc_burst_addr_gen_pkg;

    localparam int MC_BAG_AW = 32;
    localparam int MC_BAG_LW = 4;

    typedef enum logic [1:0] {
        MC_BAG_IDLE   = 2'd0,
        MC_BAG_SETTLE = 2'd1,
        MC_BAG_READY  = 2'd2,
        MC_BAG_DONE   = 2'd3
    } mc_bag_state_e;

endpackage

// File: rtl/mc_incn_r.sv
// Registered half-split incrementer: the low half and its carry are registered,
// so inc_out equals inc_in+1 one cycle after inc_in settles.
module mc_incn_r #(
    parameter int incN_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [incN_width-1:0] inc_in,
    output logic [incN_width-1:0] inc_out
);

    localparam int HW = incN_width / 2;

    logic [HW-1:0] lo_d, lo_q;
    logic          carry_d, carry_q;

    always_comb begin
        {carry_d, lo_d} = {1'b0, inc_in[HW-1:0]} + {{HW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            lo_q    <= lo_d;
            carry_q <= carry_d;
        end
    end

    // High half is completed combinationally from the held input and the registered carry.
    assign inc_out = {inc_in[incN_width-1:HW] + {{(incN_width-HW-1){1'b0}}, carry_q}, lo_q};

endmodule

// File: rtl/mc_burst_addr_gen.sv
// Burst address sequencer: one address per beat through mc_incn_r.
// Wrapping bursts are built only when MC_BURST_WRAP_EN is defined.
module mc_burst_addr_gen
    import mc_burst_addr_gen_pkg::*;
#(
    parameter int AW = MC_BAG_AW,
    parameter int LW = MC_BAG_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] burst_len,
    input  logic          wrap_mode,
    input  logic          beat_ack,
    output logic [AW-1:0] addr,
    output logic          addr_vld,
    output logic          last,
    output logic          busy,
    output logic          done
);

    mc_bag_state_e state_d, state_q;
    logic [AW-1:0] addr_d, addr_q;
    logic [LW-1:0] rem_d, rem_q;
    logic [AW-1:0] inc_out;
    logic [AW-1:0] next_addr;
    logic          addr_vld_d, addr_vld_q;
    logic          last_d, last_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;

    mc_incn_r #(.incN_width(AW)) u_inc (
        .clk    (clk),
        .rst    (rst),
        .inc_in (addr_q),
        .inc_out(inc_out)
    );

`ifdef MC_BURST_WRAP_EN
    // hold_q marks address bits frozen during a wrapping burst; zero means linear.
    logic [AW-1:0] hold_d, hold_q;
    logic          len_pow2;

    assign len_pow2  = (burst_len > LW'(1)) && ((burst_len & (burst_len - LW'(1))) == '0);
    assign next_addr = (addr_q & hold_q) | (inc_out & ~hold_q);

    always_comb begin
        hold_d = hold_q;
        if (state_q == MC_BAG_IDLE && start)
            hold_d = (wrap_mode && len_pow2) ? ~AW'(burst_len - LW'(1)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end
`else
    logic unused_wrap;
    assign unused_wrap = wrap_mode;
    assign next_addr   = inc_out;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            MC_BAG_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    rem_d   = (burst_len == '0) ? LW'(1) : burst_len;
                    state_d = MC_BAG_SETTLE;
                end
            end
            MC_BAG_SETTLE: state_d = MC_BAG_READY;
            MC_BAG_READY: begin
                if (beat_ack) begin
                    if (rem_q == LW'(1)) begin
                        state_d = MC_BAG_DONE;
                    end else begin
                        addr_d  = next_addr;
                        rem_d   = rem_q - LW'(1);
                        state_d = MC_BAG_SETTLE;
                    end
                end
            end
            default: state_d = MC_BAG_IDLE;
        endcase
        addr_vld_d = (state_d == MC_BAG_READY);
        last_d     = (state_d == MC_BAG_READY) && (rem_d == LW'(1));
        busy_d     = (state_d != MC_BAG_IDLE);
        done_d     = (state_d == MC_BAG_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MC_BAG_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            addr_vld_q <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            addr_vld_q <= addr_vld_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign addr     = addr_q;
    assign addr_vld = addr_vld_q;
    assign last     = last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mc_burst_addr_gen.sv
// Directed bench for mc_burst_addr_gen: table of bursts plus hand-written
// back-pressure and reset-abort sequences.
module tb_mc_burst_addr_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] start_addr;
    logic [3:0]  burst_len;
    logic        wrap_mode;
    logic        beat_ack;
    logic [31:0] addr;
    logic        addr_vld;
    logic        last;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0]       sa;
        logic [3:0]        len;
        logic              wrap;
        logic [2:0]        n;
        logic [3:0][31:0]  exp;
    } vec_t;

    vec_t vecs[7];

    mc_burst_addr_gen #(.AW(32), .LW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .burst_len (burst_len),
        .wrap_mode (wrap_mode),
        .beat_ack  (beat_ack),
        .addr      (addr),
        .addr_vld  (addr_vld),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] sa, input logic [3:0] len, input logic wr,
                                input logic [2:0] n, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.sa = sa; v.len = len; v.wrap = wr; v.n = n;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_vld(output int w);
        w = 0;
        while (w < 8) begin
            @(posedge clk); #1;
            w++;
            if (addr_vld) break;
        end
    endtask

    task automatic run_burst(input vec_t v, input string nm);
        int w;
        start_addr = v.sa; burst_len = v.len; wrap_mode = v.wrap; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, " busy_settle"}, {31'd0, busy}, 32'd1);
        chk({nm, " vld_settle"}, {31'd0, addr_vld}, 32'd0);
        for (int b = 0; b < int'(v.n); b++) begin
            wait_vld(w);
            chk($sformatf("%s beat%0d latency", nm, b), w, 32'd1);
            if (!addr_vld) return;
            chk($sformatf("%s beat%0d addr", nm, b), addr, v.exp[b]);
            chk($sformatf("%s beat%0d last", nm, b), {31'd0, last}, {31'd0, (b == int'(v.n) - 1)});
            beat_ack = 1'b1;
            @(posedge clk); #1;
            beat_ack = 1'b0;
        end
        chk({nm, " done_pulse"}, {31'd0, done}, 32'd1);
        chk({nm, " vld_in_done"}, {31'd0, addr_vld}, 32'd0);
        @(posedge clk); #1;
        chk({nm, " done_clear"}, {31'd0, done}, 32'd0);
        chk({nm, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int w;
        vecs[0] = mk(32'h0000_FFFE, 4'd4, 1'b0, 3'd4, 32'h0000_FFFE, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_0001);
`ifdef MC_BURST_WRAP_EN
        vecs[1] = mk(32'h0000_1006, 4'd4, 1'b1, 3'd4, 32'h1006, 32'h1007, 32'h1004, 32'h1005);
`else
        vecs[1] = mk(32'h0000_1006, 4'd4, 1'b1, 3'd4, 32'h1006, 32'h1007, 32'h1008, 32'h1009);
`endif
        vecs[2] = mk(32'h0000_1006, 4'd3, 1'b1, 3'd3, 32'h1006, 32'h1007, 32'h1008, 32'h0);
        vecs[3] = mk(32'h0000_0020, 4'd0, 1'b0, 3'd1, 32'h20, 32'h0, 32'h0, 32'h0);
        vecs[4] = mk(32'hFFFF_FFFF, 4'd2, 1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        vecs[5] = mk(32'h0000_0100, 4'd1, 1'b0, 3'd1, 32'h100, 32'h0, 32'h0, 32'h0);
        vecs[6] = mk(32'h0000_0700, 4'd2, 1'b0, 3'd2, 32'h700, 32'h701, 32'h0, 32'h0);

        rst = 1'b1; start = 1'b0; start_addr = '0; burst_len = '0; wrap_mode = 1'b0; beat_ack = 1'b0;
        #12;
        chk("rst addr", addr, 32'd0);
        chk("rst addr_vld", {31'd0, addr_vld}, 32'd0);
        chk("rst last", {31'd0, last}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure, ack in SETTLE, start while busy, start during DONE
        start_addr = 32'h40; burst_len = 4'd3; wrap_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_vld(w);
        chk("bp beat0 addr", addr, 32'h40);
        beat_ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 32'h9000;
        @(posedge clk); #1;
        beat_ack = 1'b0; start = 1'b0;
        chk("bp settle_ack addr", addr, 32'h41);
        chk("bp settle_ack vld", {31'd0, addr_vld}, 32'd1);
        chk("bp beat1 last", {31'd0, last}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d addr", k), addr, 32'h41);
            chk($sformatf("bp hold%0d vld", k), {31'd0, addr_vld}, 32'd1);
        end
        beat_ack = 1'b1;
        @(posedge clk); #1;
        beat_ack = 1'b0;
        wait_vld(w);
        chk("bp beat2 latency", w, 32'd1);
        chk("bp beat2 addr", addr, 32'h42);
        chk("bp beat2 last", {31'd0, last}, 32'd1);
        beat_ack = 1'b1;
        @(posedge clk); #1;
        beat_ack = 1'b0;
        chk("bp done", {31'd0, done}, 32'd1);
        start = 1'b1; start_addr = 32'h8000;
        @(posedge clk); #1;
        start = 1'b0;
        chk("bp start_in_done busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("bp start_in_done still idle", {31'd0, busy}, 32'd0);

        // Reset mid-burst during beat 2 of an 8-beat burst
        start_addr = 32'h500; burst_len = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_vld(w);
        beat_ack = 1'b1;
        @(posedge clk); #1;
        beat_ack = 1'b0;
        wait_vld(w);
        chk("abort beat1 addr", addr, 32'h501);
        #2 rst = 1'b1;
        #1;
        chk("abort addr", addr, 32'd0);
        chk("abort vld", {31'd0, addr_vld}, 32'd0);
        chk("abort last", {31'd0, last}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort no_done", {31'd0, done}, 32'd0);
        run_burst(vecs[6], "fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
